// File: rtl/cpu_bus_arbiter.sv
// -----------------------------------------------------------------------------
// cpu_bus_arbiter
//
// Shares the CPU's single external memory bus between the instruction-fetch
// cache (ibus, read-only) and the data cache (dbus, read/write). One requester
// is granted at a time; its command is registered onto the bus and held until
// the bus answers or the wait limit expires. The winner then receives a single
// one-cycle ready pulse together with read data and an error flag.
//
// Parameters
//   TIMEOUT        cycles o_bus_request may stay high without i_bus_ready (>= 2)
//   DATA_PRIORITY  1: data port wins every tie, 0: round-robin on ties
//
// Ports
//   i_clock, i_reset        clock (rising edge), asynchronous active-low reset
//   i_ibus_*                instruction request / address
//   o_ibus_*                instruction ready pulse, read data, timeout flag
//   i_dbus_*                data request / rw / address / write data
//   o_dbus_*                data ready pulse, read data, timeout flag
//   o_bus_*                 registered command to the external bus
//   i_bus_ready/i_bus_rdata bus completion pulse and read data
// -----------------------------------------------------------------------------
module cpu_bus_arbiter #(
    parameter int TIMEOUT       = 1023,
    parameter bit DATA_PRIORITY = 1'b0
) (
    input  logic        i_clock,
    input  logic        i_reset,
    input  logic        i_ibus_request,
    input  logic [31:0] i_ibus_address,
    output logic        o_ibus_ready,
    output logic [31:0] o_ibus_rdata,
    output logic        o_ibus_error,
    input  logic        i_dbus_request,
    input  logic        i_dbus_rw,
    input  logic [31:0] i_dbus_address,
    input  logic [31:0] i_dbus_wdata,
    output logic        o_dbus_ready,
    output logic [31:0] o_dbus_rdata,
    output logic        o_dbus_error,
    output logic        o_bus_request,
    output logic        o_bus_rw,
    output logic [31:0] o_bus_address,
    output logic [31:0] o_bus_wdata,
    input  logic        i_bus_ready,
    input  logic [31:0] i_bus_rdata
);

    localparam int CW = $clog2(TIMEOUT + 1);
    // Counter value seen on the edge that ends the TIMEOUT-th cycle of o_bus_request.
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    // Grant encoding: 0 = instruction port, 1 = data port.
    localparam logic GRANT_I = 1'b0;
    localparam logic GRANT_D = 1'b1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUS  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic          grant_q, grant_d;
    logic          last_grant_q, last_grant_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          bus_req_q, bus_req_d;
    logic          bus_rw_q, bus_rw_d;
    logic [31:0]   bus_addr_q, bus_addr_d;
    logic [31:0]   bus_wdata_q, bus_wdata_d;
    logic          ibus_ready_q, ibus_ready_d;
    logic [31:0]   ibus_rdata_q, ibus_rdata_d;
    logic          ibus_err_q, ibus_err_d;
    logic          dbus_ready_q, dbus_ready_d;
    logic [31:0]   dbus_rdata_q, dbus_rdata_d;
    logic          dbus_err_q, dbus_err_d;
    logic          winner;
    logic          granted_req;

    // Winner selection for an IDLE cycle with at least one request high.
    function automatic logic pick_winner(input logic ireq, input logic dreq,
                                         input logic last);
        logic w;
        if (ireq && !dreq) begin
            w = GRANT_I;
        end else if (!ireq && dreq) begin
            w = GRANT_D;
        end else if (DATA_PRIORITY) begin
            w = GRANT_D;
        end else begin
            // Round-robin: the port that was not served last goes next.
            w = ~last;
        end
        return w;
    endfunction

    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            state_q      <= S_IDLE;
            grant_q      <= GRANT_I;
            last_grant_q <= GRANT_I;
            cnt_q        <= '0;
            bus_req_q    <= 1'b0;
            bus_rw_q     <= 1'b0;
            bus_addr_q   <= '0;
            bus_wdata_q  <= '0;
            ibus_ready_q <= 1'b0;
            ibus_rdata_q <= '0;
            ibus_err_q   <= 1'b0;
            dbus_ready_q <= 1'b0;
            dbus_rdata_q <= '0;
            dbus_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            cnt_q        <= cnt_d;
            bus_req_q    <= bus_req_d;
            bus_rw_q     <= bus_rw_d;
            bus_addr_q   <= bus_addr_d;
            bus_wdata_q  <= bus_wdata_d;
            ibus_ready_q <= ibus_ready_d;
            ibus_rdata_q <= ibus_rdata_d;
            ibus_err_q   <= ibus_err_d;
            dbus_ready_q <= dbus_ready_d;
            dbus_rdata_q <= dbus_rdata_d;
            dbus_err_q   <= dbus_err_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        cnt_d        = cnt_q;
        bus_req_d    = bus_req_q;
        bus_rw_d     = bus_rw_q;
        bus_addr_d   = bus_addr_q;
        bus_wdata_d  = bus_wdata_q;
        ibus_rdata_d = ibus_rdata_q;
        ibus_err_d   = ibus_err_q;
        dbus_rdata_d = dbus_rdata_q;
        dbus_err_d   = dbus_err_q;
        // Ready outputs are pulses: they fall back to zero unless set below.
        ibus_ready_d = 1'b0;
        dbus_ready_d = 1'b0;
        winner       = pick_winner(i_ibus_request, i_dbus_request, last_grant_q);
        granted_req  = (grant_q == GRANT_D) ? i_dbus_request : i_ibus_request;

        case (state_q)
            S_IDLE: begin
                if (i_ibus_request || i_dbus_request) begin
                    grant_d   = winner;
                    bus_req_d = 1'b1;
                    cnt_d     = '0;
                    state_d   = S_BUS;
                    if (winner == GRANT_D) begin
                        bus_rw_d    = i_dbus_rw;
                        bus_addr_d  = i_dbus_address;
                        bus_wdata_d = i_dbus_wdata;
                    end else begin
                        // Instruction fetches are always reads with no data.
                        bus_rw_d    = 1'b0;
                        bus_addr_d  = i_ibus_address;
                        bus_wdata_d = '0;
                    end
                end
            end

            S_BUS: begin
                // A real ready on the last allowed cycle still wins over the timeout.
                if (i_bus_ready || (cnt_q == CNT_LAST)) begin
                    bus_req_d    = 1'b0;
                    last_grant_d = grant_q;
                    state_d      = S_DONE;
                    if (grant_q == GRANT_D) begin
                        dbus_ready_d = 1'b1;
                        dbus_rdata_d = i_bus_ready ? i_bus_rdata : 32'h0;
                        dbus_err_d   = ~i_bus_ready;
                    end else begin
                        ibus_ready_d = 1'b1;
                        ibus_rdata_d = i_bus_ready ? i_bus_rdata : 32'h0;
                        ibus_err_d   = ~i_bus_ready;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end

            S_DONE: begin
                // Hold off re-arbitration until the served cache lowers its request,
                // otherwise a level request would be granted a second time.
                if (!granted_req) begin
                    state_d = S_IDLE;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign o_bus_request = bus_req_q;
    assign o_bus_rw      = bus_rw_q;
    assign o_bus_address = bus_addr_q;
    assign o_bus_wdata   = bus_wdata_q;
    assign o_ibus_ready  = ibus_ready_q;
    assign o_ibus_rdata  = ibus_rdata_q;
    assign o_ibus_error  = ibus_err_q;
    assign o_dbus_ready  = dbus_ready_q;
    assign o_dbus_rdata  = dbus_rdata_q;
    assign o_dbus_error  = dbus_err_q;

endmodule

// File: tb/tb_cpu_bus_arbiter.sv
// -----------------------------------------------------------------------------
// tb_cpu_bus_arbiter
//
// Directed bench for cpu_bus_arbiter. Two instances share all inputs:
//   dut_a  DATA_PRIORITY=0 (round-robin), TIMEOUT=8
//   dut_b  DATA_PRIORITY=1 (data priority), TIMEOUT=8
// Each scenario checks the outputs of the instance it targets; a reset
// separates scenarios in which the two instances would diverge.
// -----------------------------------------------------------------------------
module tb_cpu_bus_arbiter;

    logic        clk;
    logic        rst_n;
    logic        ireq;
    logic [31:0] iaddr;
    logic        dreq;
    logic        drw;
    logic [31:0] daddr;
    logic [31:0] dwdata;
    logic        bus_ready;
    logic [31:0] bus_rdata;

    logic        a_ibus_ready, a_ibus_error, a_dbus_ready, a_dbus_error;
    logic [31:0] a_ibus_rdata, a_dbus_rdata;
    logic        a_bus_request, a_bus_rw;
    logic [31:0] a_bus_address, a_bus_wdata;

    logic        b_ibus_ready, b_ibus_error, b_dbus_ready, b_dbus_error;
    logic [31:0] b_ibus_rdata, b_dbus_rdata;
    logic        b_bus_request, b_bus_rw;
    logic [31:0] b_bus_address, b_bus_wdata;

    int total;
    int bad;

    cpu_bus_arbiter #(.TIMEOUT(8), .DATA_PRIORITY(1'b0)) dut_a (
        .i_clock        (clk),
        .i_reset        (rst_n),
        .i_ibus_request (ireq),
        .i_ibus_address (iaddr),
        .o_ibus_ready   (a_ibus_ready),
        .o_ibus_rdata   (a_ibus_rdata),
        .o_ibus_error   (a_ibus_error),
        .i_dbus_request (dreq),
        .i_dbus_rw      (drw),
        .i_dbus_address (daddr),
        .i_dbus_wdata   (dwdata),
        .o_dbus_ready   (a_dbus_ready),
        .o_dbus_rdata   (a_dbus_rdata),
        .o_dbus_error   (a_dbus_error),
        .o_bus_request  (a_bus_request),
        .o_bus_rw       (a_bus_rw),
        .o_bus_address  (a_bus_address),
        .o_bus_wdata    (a_bus_wdata),
        .i_bus_ready    (bus_ready),
        .i_bus_rdata    (bus_rdata)
    );

    cpu_bus_arbiter #(.TIMEOUT(8), .DATA_PRIORITY(1'b1)) dut_b (
        .i_clock        (clk),
        .i_reset        (rst_n),
        .i_ibus_request (ireq),
        .i_ibus_address (iaddr),
        .o_ibus_ready   (b_ibus_ready),
        .o_ibus_rdata   (b_ibus_rdata),
        .o_ibus_error   (b_ibus_error),
        .i_dbus_request (dreq),
        .i_dbus_rw      (drw),
        .i_dbus_address (daddr),
        .i_dbus_wdata   (dwdata),
        .o_dbus_ready   (b_dbus_ready),
        .o_dbus_rdata   (b_dbus_rdata),
        .o_dbus_error   (b_dbus_error),
        .o_bus_request  (b_bus_request),
        .o_bus_rw       (b_bus_rw),
        .o_bus_address  (b_bus_address),
        .o_bus_wdata    (b_bus_wdata),
        .i_bus_ready    (bus_ready),
        .i_bus_rdata    (bus_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        ireq      = 1'b0;
        dreq      = 1'b0;
        bus_ready = 1'b0;
        rst_n     = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    // Grant order for round-robin with both requests pending from reset: D, I, D, I.
    logic [3:0] rr_order_d;

    initial begin
        total      = 0;
        bad        = 0;
        rr_order_d = 4'b0101;
        rst_n      = 1'b1;
        ireq       = 1'b0;
        iaddr      = 32'h0;
        dreq       = 1'b0;
        drw        = 1'b0;
        daddr      = 32'h0;
        dwdata     = 32'h0;
        bus_ready  = 1'b0;
        bus_rdata  = 32'h0;
        #1;
        rst_n = 1'b0;
        tick();
        tick();

        // ---------------- reset state
        chk("rst_bus_request", {31'h0, a_bus_request}, 32'h0);
        chk("rst_bus_rw", {31'h0, a_bus_rw}, 32'h0);
        chk("rst_bus_address", a_bus_address, 32'h0);
        chk("rst_bus_wdata", a_bus_wdata, 32'h0);
        chk("rst_readys", {30'h0, a_ibus_ready, a_dbus_ready}, 32'h0);
        chk("rst_errors", {30'h0, a_ibus_error, a_dbus_error}, 32'h0);
        chk("rst_ibus_rdata", a_ibus_rdata, 32'h0);
        chk("rst_dbus_rdata", a_dbus_rdata, 32'h0);
        chk("rst_b_bus_request", {31'h0, b_bus_request}, 32'h0);
        rst_n = 1'b1;
        tick();

        // ---------------- single instruction read, bus answers on the third BUS cycle
        ireq  = 1'b1;
        iaddr = 32'h0000_1000;
        tick();
        chk("i_bus_request", {31'h0, a_bus_request}, 32'h1);
        chk("i_bus_rw", {31'h0, a_bus_rw}, 32'h0);
        chk("i_bus_address", a_bus_address, 32'h0000_1000);
        iaddr = 32'hFFFF_0000;
        tick();
        chk("i_cmd_held", a_bus_address, 32'h0000_1000);
        chk("i_no_early_ready", {31'h0, a_ibus_ready}, 32'h0);
        tick();
        chk("i_req_still_high", {31'h0, a_bus_request}, 32'h1);
        bus_ready = 1'b1;
        bus_rdata = 32'hDEAD_BEEF;
        tick();
        bus_ready = 1'b0;
        chk("i_ready", {31'h0, a_ibus_ready}, 32'h1);
        chk("i_rdata", a_ibus_rdata, 32'hDEAD_BEEF);
        chk("i_error", {31'h0, a_ibus_error}, 32'h0);
        chk("i_dready_quiet", {31'h0, a_dbus_ready}, 32'h0);
        chk("i_bus_req_dropped", {31'h0, a_bus_request}, 32'h0);
        ireq = 1'b0;
        tick();
        chk("i_ready_single_pulse", {31'h0, a_ibus_ready}, 32'h0);
        chk("i_rdata_kept", a_ibus_rdata, 32'hDEAD_BEEF);

        // ---------------- single data write, minimum round trip
        dreq   = 1'b1;
        drw    = 1'b1;
        daddr  = 32'h2000_0004;
        dwdata = 32'h1234_5678;
        tick();
        chk("d_bus_request", {31'h0, a_bus_request}, 32'h1);
        chk("d_bus_rw", {31'h0, a_bus_rw}, 32'h1);
        chk("d_bus_address", a_bus_address, 32'h2000_0004);
        chk("d_bus_wdata", a_bus_wdata, 32'h1234_5678);
        bus_ready = 1'b1;
        bus_rdata = 32'h0;
        tick();
        bus_ready = 1'b0;
        chk("d_ready", {31'h0, a_dbus_ready}, 32'h1);
        chk("d_iready_quiet", {31'h0, a_ibus_ready}, 32'h0);
        chk("d_error", {31'h0, a_dbus_error}, 32'h0);
        dreq = 1'b0;
        drw  = 1'b0;
        tick();
        chk("d_ready_single_pulse", {31'h0, a_dbus_ready}, 32'h0);

        // ---------------- round-robin with both requests pending (dut_a)
        do_reset();
        iaddr  = 32'h0000_0100;
        daddr  = 32'h0000_0200;
        dwdata = 32'h0;
        ireq   = 1'b1;
        dreq   = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("rr_bus_request", {31'h0, a_bus_request}, 32'h1);
            chk("rr_bus_address", a_bus_address, rr_order_d[k] ? 32'h0000_0200 : 32'h0000_0100);
            bus_ready = 1'b1;
            bus_rdata = 32'hA000_0000 + 32'(k);
            tick();
            bus_ready = 1'b0;
            chk("rr_dready", {31'h0, a_dbus_ready}, {31'h0, rr_order_d[k]});
            chk("rr_iready", {31'h0, a_ibus_ready}, {31'h0, ~rr_order_d[k]});
            chk("rr_rdata", rr_order_d[k] ? a_dbus_rdata : a_ibus_rdata, 32'hA000_0000 + 32'(k));
            if (rr_order_d[k]) dreq = 1'b0;
            else ireq = 1'b0;
            tick();
            chk("rr_no_grant_in_done", {31'h0, a_bus_request}, 32'h0);
            ireq = 1'b1;
            dreq = 1'b1;
        end

        // ---------------- data priority, D re-requests after each completion (dut_b)
        do_reset();
        ireq = 1'b1;
        dreq = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("dp_bus_address", b_bus_address, 32'h0000_0200);
            bus_ready = 1'b1;
            bus_rdata = 32'hB000_0000 + 32'(k);
            tick();
            bus_ready = 1'b0;
            chk("dp_dready", {31'h0, b_dbus_ready}, 32'h1);
            chk("dp_iready_quiet", {31'h0, b_ibus_ready}, 32'h0);
            chk("dp_drdata", b_dbus_rdata, 32'hB000_0000 + 32'(k));
            dreq = 1'b0;
            tick();
            chk("dp_no_grant_in_done", {31'h0, b_bus_request}, 32'h0);
            dreq = (k != 2);
        end
        tick();
        chk("dp_i_after_d_drops", b_bus_address, 32'h0000_0100);
        chk("dp_i_bus_request", {31'h0, b_bus_request}, 32'h1);
        bus_ready = 1'b1;
        bus_rdata = 32'h0000_00CC;
        tick();
        bus_ready = 1'b0;
        chk("dp_iready", {31'h0, b_ibus_ready}, 32'h1);
        chk("dp_irdata", b_ibus_rdata, 32'h0000_00CC);
        ireq = 1'b0;
        tick();

        // ---------------- timeout on a data read (dut_a)
        do_reset();
        dreq  = 1'b1;
        drw   = 1'b0;
        daddr = 32'h0000_0300;
        tick();
        bus_ready = 1'b1;
        bus_rdata = 32'h5555_AAAA;
        tick();
        bus_ready = 1'b0;
        chk("to_pre_rdata", a_dbus_rdata, 32'h5555_AAAA);
        dreq = 1'b0;
        tick();
        dreq = 1'b1;
        tick();
        chk("to_req_cycle1", {31'h0, a_bus_request}, 32'h1);
        for (int i = 2; i <= 8; i++) begin
            tick();
            chk("to_req_held", {31'h0, a_bus_request}, 32'h1);
            chk("to_no_early_ready", {31'h0, a_dbus_ready}, 32'h0);
        end
        tick();
        chk("to_req_dropped", {31'h0, a_bus_request}, 32'h0);
        chk("to_dready", {31'h0, a_dbus_ready}, 32'h1);
        chk("to_derror", {31'h0, a_dbus_error}, 32'h1);
        chk("to_drdata_zero", a_dbus_rdata, 32'h0);
        chk("to_iready_quiet", {31'h0, a_ibus_ready}, 32'h0);
        dreq = 1'b0;
        tick();
        chk("to_ready_single_pulse", {31'h0, a_dbus_ready}, 32'h0);

        // spurious bus ready while idle
        bus_ready = 1'b1;
        bus_rdata = 32'h7777_7777;
        tick();
        bus_ready = 1'b0;
        chk("spur_readys", {30'h0, a_ibus_ready, a_dbus_ready}, 32'h0);
        chk("spur_bus_request", {31'h0, a_bus_request}, 32'h0);
        chk("spur_drdata_kept", a_dbus_rdata, 32'h0);

        // next request proceeds normally
        ireq  = 1'b1;
        iaddr = 32'h0000_0400;
        tick();
        chk("after_to_request", {31'h0, a_bus_request}, 32'h1);
        chk("after_to_address", a_bus_address, 32'h0000_0400);
        bus_ready = 1'b1;
        bus_rdata = 32'h600D_F00D;
        tick();
        bus_ready = 1'b0;
        chk("after_to_iready", {31'h0, a_ibus_ready}, 32'h1);
        chk("after_to_ierror", {31'h0, a_ibus_error}, 32'h0);
        chk("after_to_irdata", a_ibus_rdata, 32'h600D_F00D);
        chk("after_to_derror_kept", {31'h0, a_dbus_error}, 32'h1);
        ireq = 1'b0;
        tick();

        // ---------------- reset during BUS (dut_a)
        dreq  = 1'b1;
        daddr = 32'h0000_0500;
        tick();
        chk("mid_bus_request", {31'h0, a_bus_request}, 32'h1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_bus_request", {31'h0, a_bus_request}, 32'h0);
        chk("mid_rst_bus_address", a_bus_address, 32'h0);
        chk("mid_rst_readys", {30'h0, a_ibus_ready, a_dbus_ready}, 32'h0);
        chk("mid_rst_derror", {31'h0, a_dbus_error}, 32'h0);
        chk("mid_rst_irdata", a_ibus_rdata, 32'h0);
        dreq  = 1'b0;
        ireq  = 1'b1;
        iaddr = 32'h0000_0600;
        tick();
        chk("in_rst_no_request", {31'h0, a_bus_request}, 32'h0);
        rst_n = 1'b1;
        tick();
        chk("post_rst_request", {31'h0, a_bus_request}, 32'h1);
        chk("post_rst_address", a_bus_address, 32'h0000_0600);
        chk("post_rst_rw", {31'h0, a_bus_rw}, 32'h0);
        chk("post_rst_no_dready", {31'h0, a_dbus_ready}, 32'h0);
        bus_ready = 1'b1;
        bus_rdata = 32'h0000_0001;
        tick();
        bus_ready = 1'b0;
        chk("post_rst_iready", {31'h0, a_ibus_ready}, 32'h1);
        chk("post_rst_irdata", a_ibus_rdata, 32'h0000_0001);
        ireq = 1'b0;
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
